// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared constants, occupancy type and popcount helper
package parking_pkg;

  localparam int MAX_SPACES             = 8;
  localparam int DEFAULT_DEBOUNCE_TICKS = 4;

  typedef enum logic {
    FREE     = 1'b0,
    OCCUPIED = 1'b1
  } occ_e;

  // Number of occupied spaces in a full-width occupancy vector.
  function automatic int unsigned popcount(input logic [MAX_SPACES-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_SPACES; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// rtl/sensor_debounce.sv - one channel: synchroniser, polarity, debounce, events
module sensor_debounce
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS,
  parameter bit ACTIVE_HIGH    = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_tick,
  input  logic pin,
  output logic parked,
  output logic arrive,
  output logic depart
);

  localparam int            CW       = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] LAST     = CW'(DEBOUNCE_TICKS - 1);
  // Sync flops come out of reset at the "free" pin level so release is quiet.
  localparam logic          IDLE_PIN = ACTIVE_HIGH ? 1'b0 : 1'b1;

  logic          sync1;
  logic          sync2;
  occ_e          level;
  occ_e          state;
  logic [CW-1:0] cnt;

  // Two-flop synchroniser for the asynchronous sensor pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= IDLE_PIN;
      sync2 <= IDLE_PIN;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

  assign level = occ_e'(ACTIVE_HIGH ? sync2 : ~sync2);

  // Accept a new level only after it disagrees with the current state for
  // DEBOUNCE_TICKS consecutive ticks; any agreement restarts qualification.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= FREE;
      cnt    <= '0;
      arrive <= 1'b0;
      depart <= 1'b0;
    end else begin
      arrive <= 1'b0;
      depart <= 1'b0;
      if (level == state) begin
        cnt <= '0;
      end else if (sample_tick) begin
        if (cnt == LAST) begin
          state  <= level;
          cnt    <= '0;
          arrive <= (level == OCCUPIED);
          depart <= (level == FREE);
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign parked = (state == OCCUPIED);

endmodule

// File: rtl/parking_sensor_array.sv
// rtl/parking_sensor_array.sv - N_CH debounced parking sensors with occupied count
module parking_sensor_array
  import parking_pkg::*;
#(
  parameter int N_CH           = 8,
  parameter int DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS,
  parameter bit ACTIVE_HIGH    = 1'b1,
  parameter int CNT_W          = $clog2(N_CH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_tick,
  input  logic [N_CH-1:0]  JA,
  output logic [N_CH-1:0]  parked,
  output logic [N_CH-1:0]  arrive,
  output logic [N_CH-1:0]  depart,
  output logic [CNT_W-1:0] occ_count
);

  logic [MAX_SPACES-1:0] parked_wide;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    sensor_debounce #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .ACTIVE_HIGH   (ACTIVE_HIGH)
    ) u_deb (
      .clk        (clk),
      .rst_n      (rst_n),
      .sample_tick(sample_tick),
      .pin        (JA[i]),
      .parked     (parked[i]),
      .arrive     (arrive[i]),
      .depart     (depart[i])
    );
  end

  assign parked_wide = MAX_SPACES'(parked);

  // Registered occupied-space count, one cycle behind parked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_count <= '0;
    end else begin
      occ_count <= CNT_W'(popcount(parked_wide));
    end
  end

endmodule

// File: tb/tb_parking_sensor_array.sv
// tb/tb_parking_sensor_array.sv - directed and random checks against a reference model
module tb_parking_sensor_array;

  localparam int ND = 3;
  localparam int N  = 8;
  localparam int DEB [ND] = '{4, 4, 1};
  localparam bit AH  [ND] = '{1'b1, 1'b0, 1'b1};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sample_tick = 1'b1;
  logic [N-1:0] ja     [ND];
  logic [N-1:0] parked [ND];
  logic [N-1:0] arrive [ND];
  logic [N-1:0] depart [ND];
  logic [3:0]   occ    [ND];

  int tests_run    = 0;
  int tests_failed = 0;

  // reference model: pin history, accepted occupancy, disagreeing-tick runs
  logic [N-1:0] pin_d1 [ND];
  logic [N-1:0] pin_d2 [ND];
  logic [N-1:0] m_park [ND];
  logic [N-1:0] m_arr  [ND];
  logic [N-1:0] m_dep  [ND];
  int           m_occ  [ND];
  int           run    [ND][N];

  always #5 clk = ~clk;

  parking_sensor_array #(.N_CH(8), .DEBOUNCE_TICKS(4), .ACTIVE_HIGH(1'b1)) dut_h (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .JA(ja[0]),
    .parked(parked[0]), .arrive(arrive[0]), .depart(depart[0]), .occ_count(occ[0]));

  parking_sensor_array #(.N_CH(8), .DEBOUNCE_TICKS(4), .ACTIVE_HIGH(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .JA(ja[1]),
    .parked(parked[1]), .arrive(arrive[1]), .depart(depart[1]), .occ_count(occ[1]));

  parking_sensor_array #(.N_CH(8), .DEBOUNCE_TICKS(1), .ACTIVE_HIGH(1'b1)) dut_1 (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .JA(ja[2]),
    .parked(parked[2]), .arrive(arrive[2]), .depart(depart[2]), .occ_count(occ[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      pin_d1[d] = AH[d] ? '0 : '1;
      pin_d2[d] = AH[d] ? '0 : '1;
      m_park[d] = '0;
      m_arr[d]  = '0;
      m_dep[d]  = '0;
      m_occ[d]  = 0;
      for (int c = 0; c < N; c++) run[d][c] = 0;
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < ND; d++) begin
      logic [N-1:0] lvl;
      lvl = AH[d] ? pin_d2[d] : ~pin_d2[d];
      m_occ[d] = $countones(m_park[d]);
      m_arr[d] = '0;
      m_dep[d] = '0;
      for (int c = 0; c < N; c++) begin
        if (lvl[c] == m_park[d][c]) begin
          run[d][c] = 0;
        end else if (sample_tick) begin
          run[d][c]++;
          if (run[d][c] == DEB[d]) begin
            m_park[d][c] = lvl[c];
            if (lvl[c]) m_arr[d][c] = 1'b1;
            else        m_dep[d][c] = 1'b1;
            run[d][c] = 0;
          end
        end
      end
      pin_d2[d] = pin_d1[d];
      pin_d1[d] = ja[d];
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("d%0d parked", d), parked[d], m_park[d]);
      chk($sformatf("d%0d arrive", d), arrive[d], m_arr[d]);
      chk($sformatf("d%0d depart", d), depart[d], m_dep[d]);
      chk($sformatf("d%0d occ", d),    occ[d],    m_occ[d]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    else       model_reset();
    #1;
    compare_all();
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
  endtask

  int rise_edge;

  initial begin
    model_reset();
    ja[0] = 8'hFF;
    ja[1] = 8'hFF;
    ja[2] = 8'hFF;
    sample_tick = 1'b1;

    // reset held with all pins active
    repeat (3) step();
    chk("rst parked", parked[0], 8'h00);
    chk("rst occ", occ[0], 0);

    // release: all spaces accepted at edge 6, count one cycle later
    rst_n = 1'b1;
    repeat (5) step();
    chk("rel parked@5", parked[0], 8'h00);
    step();
    chk("rel parked@6", parked[0], 8'hFF);
    chk("rel arrive@6", arrive[0], 8'hFF);
    step();
    chk("rel occ@7", occ[0], 8);
    chk("rel arrive@7", arrive[0], 8'h00);

    // clear, then a 3-clock glitch on channel 2 is rejected
    ja[0] = 8'h00;
    ja[2] = 8'h00;
    repeat (8) step();
    ja[0] = 8'h04;
    repeat (3) step();
    ja[0] = 8'h00;
    repeat (8) step();
    chk("reject parked", parked[0], 8'h00);
    chk("reject occ", occ[0], 0);

    // accept and depart on channel 2
    ja[0] = 8'h04;
    repeat (5) step();
    chk("acc parked@5", parked[0], 8'h00);
    step();
    chk("acc parked@6", parked[0], 8'h04);
    chk("acc arrive@6", arrive[0], 8'h04);
    step();
    chk("acc occ", occ[0], 1);
    repeat (3) step();
    ja[0] = 8'h00;
    repeat (5) step();
    step();
    chk("dep parked@6", parked[0], 8'h00);
    chk("dep depart@6", depart[0], 8'h04);
    step();
    chk("dep occ", occ[0], 0);

    // tick gating: one tick every 4 clocks, plus a short glitch on channel 1
    ja[0] = 8'h01;
    rise_edge = -1;
    for (int k = 0; k < 40; k++) begin
      sample_tick = (k % 4 == 3);
      if (k == 5) ja[0] = 8'h03;
      if (k == 6) ja[0] = 8'h01;
      step();
      if (rise_edge < 0 && parked[0][0]) rise_edge = k + 1;
    end
    chk("gate rise edge", rise_edge, 16);
    chk("gate glitch ignored", parked[0][1], 1'b0);
    sample_tick = 1'b1;

    // active-low polarity and simultaneous arrive/depart
    ja[1] = 8'h0F;
    repeat (5) step();
    step();
    chk("pol parked", parked[1], 8'hF0);
    chk("pol arrive", arrive[1], 8'hF0);
    step();
    chk("pol occ", occ[1], 4);
    ja[1] = 8'hF0;
    repeat (5) step();
    step();
    chk("swap arrive", arrive[1], 8'h0F);
    chk("swap depart", depart[1], 8'hF0);
    step();
    chk("swap occ", occ[1], 4);

    // reset during qualification loses the partial count
    ja[0] = 8'h80;
    repeat (8) step();
    ja[0] = 8'hA0;
    repeat (4) step();
    assert_reset();
    chk("midrst parked", parked[0], 8'h00);
    chk("midrst occ", occ[0], 0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (5) step();
    chk("requal parked@5", parked[0], 8'h00);
    step();
    chk("requal parked@6", parked[0], 8'hA0);
    chk("requal arrive@6", arrive[0], 8'hA0);

    // random pins, ticks and occasional resets against the model
    for (int k = 0; k < 3000; k++) begin
      for (int d = 0; d < ND; d++) begin
        for (int c = 0; c < N; c++) begin
          if ($urandom_range(0, 7) == 0) ja[d][c] = ~ja[d][c];
        end
      end
      sample_tick = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 399) == 0) begin
        assert_reset();
        step();
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
